// File: rtl/game_step_sequencer_if.sv
// Request/done handshake bundle between the step sequencer and the snake/food datapath.
interface game_step_sequencer_if;
    logic move_req;
    logic move_done;
    logic coll_req;
    logic coll_done;
    logic coll_hit;
    logic coll_food;
    logic food_req;
    logic food_done;

    modport master (
        output move_req, coll_req, food_req,
        input  move_done, coll_done, coll_hit, coll_food, food_done
    );

    modport slave (
        input  move_req, coll_req, food_req,
        output move_done, coll_done, coll_hit, coll_food, food_done
    );
endinterface

// File: rtl/game_step_sequencer.sv
// Runs one move/collision/food update per game tick, aligned to vblank, and owns
// the top-level game state, score, step count and tick-overrun accounting.
module game_step_sequencer #(
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                         vga_clk,
    input  logic                         rst_sync,
    input  logic                         game_tick,
    input  logic                         vblank,
    input  logic                         start_pulse,
    input  logic                         pause_pulse,
    game_step_sequencer_if.master        hs,
    output logic                         init_pulse,
    output logic                         commit_pulse,
    output logic [1:0]                   game_state,
    output logic [15:0]                  score,
    output logic [15:0]                  step_count,
    output logic [7:0]                   overrun_cnt,
    output logic                         fault
);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_PAUSE, S_MOVE, S_COLL, S_FOOD, S_COMMIT, S_OVER
    } state_t;

    state_t      state, nxt;
    logic        pending, pause_lat;
    logic [15:0] phase_cnt;
    logic        in_step, step_go, done_now, timeout, restart;

    always_comb begin
        in_step  = (state == S_MOVE) || (state == S_COLL) || (state == S_FOOD) || (state == S_COMMIT);
        step_go  = (state == S_RUN) && (game_tick || pending) && vblank;
        restart  = ((state == S_IDLE) || (state == S_OVER)) && start_pulse;
        done_now = 1'b0;
        case (state)
            S_MOVE:  done_now = hs.move_done;
            S_COLL:  done_now = hs.coll_done;
            S_FOOD:  done_now = hs.food_done;
            default: done_now = 1'b0;
        endcase
        // Count is 0 on the first cycle of a phase, so req is high exactly ACK_TIMEOUT cycles.
        timeout = ((state == S_MOVE) || (state == S_COLL) || (state == S_FOOD)) &&
                  !done_now && (phase_cnt == 16'(ACK_TIMEOUT - 1));

        nxt = state;
        case (state)
            S_IDLE, S_OVER: if (start_pulse) nxt = S_RUN;
            S_RUN: begin
                if (step_go)          nxt = S_MOVE;
                else if (pause_pulse) nxt = S_PAUSE;
            end
            S_PAUSE: if (pause_pulse) nxt = S_RUN;
            S_MOVE: begin
                if (done_now)     nxt = S_COLL;
                else if (timeout) nxt = S_OVER;
            end
            S_COLL: begin
                if (done_now) begin
                    if (hs.coll_hit)       nxt = S_OVER;
                    else if (hs.coll_food) nxt = S_FOOD;
                    else                   nxt = S_COMMIT;
                end else if (timeout) begin
                    nxt = S_OVER;
                end
            end
            S_FOOD: begin
                if (done_now)     nxt = S_COMMIT;
                else if (timeout) nxt = S_OVER;
            end
            S_COMMIT: nxt = (pause_lat ^ pause_pulse) ? S_PAUSE : S_RUN;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or posedge rst_sync) begin
        if (rst_sync) begin
            state        <= S_IDLE;
            hs.move_req  <= 1'b0;
            hs.coll_req  <= 1'b0;
            hs.food_req  <= 1'b0;
            init_pulse   <= 1'b0;
            commit_pulse <= 1'b0;
            game_state   <= 2'b00;
            score        <= '0;
            step_count   <= '0;
            overrun_cnt  <= '0;
            fault        <= 1'b0;
            pending      <= 1'b0;
            pause_lat    <= 1'b0;
            phase_cnt    <= '0;
        end else begin
            state        <= nxt;
            hs.move_req  <= (nxt == S_MOVE);
            hs.coll_req  <= (nxt == S_COLL);
            hs.food_req  <= (nxt == S_FOOD);
            commit_pulse <= (nxt == S_COMMIT);
            init_pulse   <= restart;
            phase_cnt    <= (nxt != state) ? 16'd0 : phase_cnt + 16'd1;
            case (nxt)
                S_IDLE:  game_state <= 2'b00;
                S_PAUSE: game_state <= 2'b10;
                S_OVER:  game_state <= 2'b11;
                default: game_state <= 2'b01;
            endcase

            if (restart) begin
                score       <= '0;
                step_count  <= '0;
                overrun_cnt <= '0;
                fault       <= 1'b0;
                pending     <= 1'b0;
                pause_lat   <= 1'b0;
            end else if (state == S_RUN) begin
                if (step_go) begin
                    // A fresh tick alongside a pending-driven start becomes the next pending.
                    pending   <= pending & game_tick;
                    pause_lat <= pause_pulse;
                end else if (pause_pulse) begin
                    pending <= 1'b0;
                end else if (game_tick) begin
                    if (pending && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
                    pending <= 1'b1;
                end
            end else if (in_step) begin
                if (game_tick) begin
                    if (pending && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
                    pending <= 1'b1;
                end
                if (pause_pulse && state != S_COMMIT) pause_lat <= ~pause_lat;
                if (state == S_COLL && nxt == S_FOOD && score != 16'hFFFF) score <= score + 16'd1;
                if (state == S_COMMIT) step_count <= step_count + 16'd1;
                if (nxt == S_OVER) pause_lat <= 1'b0;
                if (state == S_COMMIT) pause_lat <= 1'b0;
                if (timeout) fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_game_step_sequencer.sv
// Directed scenarios plus randomized play against a phase-level reference model.
module tb_game_step_sequencer;
    localparam int TO = 16;

    logic        vga_clk = 1'b0;
    logic        rst_sync, game_tick, vblank, start_pulse, pause_pulse;
    logic        init_pulse, commit_pulse, fault;
    logic [1:0]  game_state;
    logic [15:0] score, step_count;
    logic [7:0]  overrun_cnt;

    game_step_sequencer_if hs();

    game_step_sequencer #(.ACK_TIMEOUT(TO)) dut (
        .vga_clk     (vga_clk),
        .rst_sync    (rst_sync),
        .game_tick   (game_tick),
        .vblank      (vblank),
        .start_pulse (start_pulse),
        .pause_pulse (pause_pulse),
        .hs          (hs),
        .init_pulse  (init_pulse),
        .commit_pulse(commit_pulse),
        .game_state  (game_state),
        .score       (score),
        .step_count  (step_count),
        .overrun_cnt (overrun_cnt),
        .fault       (fault)
    );

    always #5 vga_clk = ~vga_clk;

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode is the reported game state; ph is the step phase
    // (0 none, 1 move, 2 coll, 3 food, 4 commit), age the cycles spent in it.
    int m_mode, m_ph, m_age, m_score, m_steps, m_ovr;
    bit m_pend, m_plat, m_flt, m_init;

    bit rnd = 0;
    int lat_move = 0, lat_coll = 0, lat_food = 0;
    bit res_hit = 0, res_food = 0;

    task automatic model_reset();
        m_mode = 0; m_ph = 0; m_age = 0; m_score = 0; m_steps = 0; m_ovr = 0;
        m_pend = 0; m_plat = 0; m_flt = 0; m_init = 0;
    endtask

    task automatic model_tmo();
        m_age++;
        if (m_age == TO) begin
            m_flt = 1; m_ph = 0; m_mode = 3; m_plat = 0;
        end
    endtask

    task automatic model_step();
        m_init = 0;
        if (m_ph == 0 && (m_mode == 0 || m_mode == 3)) begin
            if (start_pulse) begin
                m_mode = 1; m_init = 1; m_score = 0; m_steps = 0; m_ovr = 0;
                m_flt = 0; m_pend = 0; m_plat = 0;
            end
        end else if (m_ph == 0 && m_mode == 2) begin
            if (pause_pulse) m_mode = 1;
        end else if (m_ph == 0) begin
            if ((game_tick || m_pend) && vblank) begin
                m_plat = pause_pulse;
                m_pend = m_pend && game_tick;
                m_ph = 1; m_age = 0;
            end else if (pause_pulse) begin
                m_mode = 2; m_pend = 0;
            end else if (game_tick) begin
                if (m_pend && m_ovr < 255) m_ovr++;
                m_pend = 1;
            end
        end else begin
            if (game_tick) begin
                if (m_pend) begin
                    if (m_ovr < 255) m_ovr++;
                end else m_pend = 1;
            end
            if (pause_pulse && m_ph != 4) m_plat = !m_plat;
            case (m_ph)
                1: if (hs.move_done) begin m_ph = 2; m_age = 0; end else model_tmo();
                2: if (hs.coll_done) begin
                       m_age = 0;
                       if (hs.coll_hit) begin m_ph = 0; m_mode = 3; m_plat = 0; end
                       else if (hs.coll_food) begin m_ph = 3; if (m_score < 65535) m_score++; end
                       else m_ph = 4;
                   end else model_tmo();
                3: if (hs.food_done) begin m_ph = 4; m_age = 0; end else model_tmo();
                default: begin
                    m_mode = (m_plat ^ pause_pulse) ? 2 : 1;
                    m_plat = 0; m_steps = (m_steps + 1) % 65536; m_ph = 0;
                end
            endcase
        end
    endtask

    task automatic drive_inputs();
        if (rnd) begin
            if (m_ph != 0 && m_age == 0) begin
                int l;
                l = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(0, 4);
                if (m_ph == 1) lat_move = l; else if (m_ph == 2) lat_coll = l; else lat_food = l;
            end
            game_tick   = ($urandom_range(0, 99) < 15);
            vblank      = ($urandom_range(0, 99) < 60);
            start_pulse = ($urandom_range(0, 99) < 2);
            pause_pulse = ($urandom_range(0, 99) < 3);
            hs.coll_hit  = ($urandom_range(0, 99) < 15);
            hs.coll_food = ($urandom_range(0, 99) < 40);
        end else begin
            hs.coll_hit  = res_hit;
            hs.coll_food = res_food;
        end
        hs.move_done = (m_ph == 1 && m_age == lat_move);
        hs.coll_done = (m_ph == 2 && m_age == lat_coll);
        hs.food_done = (m_ph == 3 && m_age == lat_food);
        // Stray dones outside their phase must be ignored.
        if (rnd && $urandom_range(0, 15) == 0) begin
            if (m_ph != 1) hs.move_done = 1'b1;
            if (m_ph != 2) hs.coll_done = 1'b1;
            if (m_ph != 3) hs.food_done = 1'b1;
        end
    endtask

    task automatic cyc();
        drive_inputs();
        model_step();
        @(posedge vga_clk);
        #1;
        check("move_req", hs.move_req, 32'(m_ph == 1));
        check("coll_req", hs.coll_req, 32'(m_ph == 2));
        check("food_req", hs.food_req, 32'(m_ph == 3));
        check("commit",   commit_pulse, 32'(m_ph == 4));
        check("init",     init_pulse, 32'(m_init));
        check("state",    game_state, (m_ph != 0) ? 32'd1 : 32'(m_mode));
        check("score",    score, 32'(m_score));
        check("steps",    step_count, 32'(m_steps));
        check("overrun",  overrun_cnt, 32'(m_ovr));
        check("fault",    fault, 32'(m_flt));
        game_tick = 0; start_pulse = 0; pause_pulse = 0;
    endtask

    int nfood, ncommit, ncoll;

    initial begin
        rst_sync = 1; game_tick = 0; vblank = 0; start_pulse = 0; pause_pulse = 0;
        hs.move_done = 0; hs.coll_done = 0; hs.coll_hit = 0; hs.coll_food = 0; hs.food_done = 0;
        model_reset();
        repeat (2) @(posedge vga_clk);
        #1;
        check("rst_state", game_state, 0);
        check("rst_reqs", {hs.move_req, hs.coll_req, hs.food_req}, 0);
        check("rst_pulses", {init_pulse, commit_pulse}, 0);
        check("rst_cnts", {score, step_count, overrun_cnt, fault}, 0);
        rst_sync = 0;

        // Start and a zero-wait step without food.
        vblank = 1; start_pulse = 1; cyc();
        check("start_init", init_pulse, 1);
        check("start_run", game_state, 1);
        cyc();
        game_tick = 1; cyc(); check("t1_move", hs.move_req, 1);
        cyc(); check("t2_coll", hs.coll_req, 1);
        cyc(); check("t3_commit", commit_pulse, 1);
        cyc(); check("t4_steps", step_count, 1); check("t4_score", score, 0);

        // Food with a 5-cycle respawn.
        res_food = 1; lat_food = 4; nfood = 0; ncommit = 0;
        game_tick = 1;
        repeat (12) begin cyc(); nfood += hs.food_req; ncommit += commit_pulse; end
        check("food_len", nfood, 5); check("food_commits", ncommit, 1); check("food_score", score, 1);

        // Hit wins over food.
        res_hit = 1; nfood = 0; ncommit = 0; game_tick = 1;
        repeat (6) begin cyc(); nfood += hs.food_req; ncommit += commit_pulse; end
        check("hit_over", game_state, 3); check("hit_nofood", nfood, 0);
        check("hit_nocommit", ncommit, 0); check("hit_score", score, 1);
        res_hit = 0; res_food = 0;
        start_pulse = 1; cyc();
        check("restart_init", init_pulse, 1);
        check("restart_cnts", {score, step_count, overrun_cnt}, 0);
        cyc();

        // Three ticks during a stalled MOVE: one pending, two overruns.
        lat_move = 12; game_tick = 1; cyc();
        vblank = 0;
        for (int i = 0; i < 16; i++) begin
            game_tick = (i == 2 || i == 5 || i == 8);
            cyc();
        end
        check("ovr_cnt", overrun_cnt, 2);
        lat_move = 0;
        repeat (3) cyc();
        check("pend_wait", hs.move_req, 0);
        vblank = 1; cyc();
        check("pend_go", hs.move_req, 1);
        repeat (4) cyc();

        // Pause latched during COLL.
        lat_coll = 3; game_tick = 1; cyc(); cyc();
        pause_pulse = 1; cyc();
        ncommit = 0;
        repeat (6) begin cyc(); ncommit += commit_pulse; end
        check("pause_commit", ncommit, 1); check("pause_state", game_state, 2);
        game_tick = 1; cyc(); game_tick = 1; cyc();
        check("pause_ign", hs.move_req, 0);
        pause_pulse = 1; cyc();
        check("unpause", game_state, 1);
        cyc();

        // COLL timeout.
        lat_coll = 100; ncoll = 0; game_tick = 1; cyc();
        repeat (25) begin cyc(); ncoll += hs.coll_req; end
        check("to_len", ncoll, TO); check("to_fault", fault, 1); check("to_over", game_state, 3);
        lat_coll = 0;

        // Asynchronous reset in the middle of MOVE.
        start_pulse = 1; cyc(); cyc();
        lat_move = 100; game_tick = 1; cyc(); cyc();
        check("pre_rst_move", hs.move_req, 1);
        #2 rst_sync = 1;
        #1;
        check("async_move", hs.move_req, 0);
        check("async_idle", game_state, 0);
        model_reset();
        @(posedge vga_clk); #1;
        rst_sync = 0;
        lat_move = 0;
        cyc();

        // Randomized play.
        rnd = 1;
        repeat (3000) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
